// File: rtl/exec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exec_ctrl_pkg
//   Shared definitions for the run/step/halt sequencer and the hex display mux.
//   - exec_mode_e : 2-bit mode encoding reported on exec_controller.mode.
//   - STEP_CNT_W  : width of the issued-pulse counter.
// -----------------------------------------------------------------------------
package exec_ctrl_pkg;

   localparam int STEP_CNT_W = 16;

   // The display mux decodes these values directly, so the encoding is fixed.
   typedef enum logic [1:0] {
      MODE_IDLE   = 2'b00,
      MODE_RUN    = 2'b01,
      MODE_PAUSED = 2'b10,
      MODE_STEP   = 2'b11
   } exec_mode_e;

endpackage : exec_ctrl_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser, stability counter and rising-edge detector for one
//   raw board button.
// Ports
//   clk      in  board clock
//   reset_n  in  asynchronous active-low reset
//   btn_raw  in  raw asynchronous button
//   level    out debounced button level
//   press    out one-cycle pulse on a debounced 0->1 transition
// Timing: a raw edge reaches the second synchroniser flop after 2 edges, the
//   level flips after DB_CYCLES further equal samples, and press is high in the
//   cycle after that flip, so the consumer acts on it 2+DB_CYCLES+1 edges after
//   the raw edge.
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   // The counter only has to reach DB_CYCLES-1.
   localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync0;
   logic          r_sync1;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync0   <= 1'b0;
         r_sync1   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync0   <= btn_raw;
         r_sync1   <= r_sync0;
         r_level_d <= r_level;
         // Count consecutive samples that disagree with the accepted level;
         // any agreeing sample restarts the count, so bounces shorter than
         // DB_CYCLES never reach the level.
         if (r_sync1 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync1;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign level = r_level;
   // Built from two flops, so press is glitch-free and exactly one cycle wide.
   assign press = r_level & ~r_level_d;

endmodule : btn_debounce

// File: rtl/exec_controller.sv
// -----------------------------------------------------------------------------
// exec_controller
//   Run/step/halt sequencer for the multicycle CPU. Issues a one-cycle clock
//   enable (cpu_en) on the board clock instead of a divided slow clock.
// Ports
//   clk, reset_n          board clock, asynchronous active-low reset
//   btn_run/step/halt     raw asynchronous buttons
//   bp_en, bp_addr        halt-on-store breakpoint enable and address
//   mem_write, mem_adr    CPU store strobe/address, valid in the cpu_en cycle
//   cpu_en                CPU advances one state on the edge where cpu_en=1
//   mode                  current sequencer state (exec_mode_e encoding)
//   halted_bp             PAUSED was entered because of a breakpoint hit
//   step_count            number of cpu_en pulses issued, wraps at 2^16
// Mode is the FSM state register itself, so it doubles as the state probe.
// -----------------------------------------------------------------------------
module exec_controller
   import exec_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 30_000_000,
   parameter int DB_CYCLES = 1_000_000,
   parameter int AW        = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  btn_run,
   input  logic                  btn_step,
   input  logic                  btn_halt,
   input  logic                  bp_en,
   input  logic [AW-1:0]         bp_addr,
   input  logic                  mem_write,
   input  logic [AW-1:0]         mem_adr,
   output logic                  cpu_en,
   output logic [1:0]            mode,
   output logic                  halted_bp,
   output logic [STEP_CNT_W-1:0] step_count
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   // ---------------------------------------------------------------- buttons
   logic       w_run_press;
   logic       w_step_press;
   logic       w_halt_press;
   logic       w_run_level;
   logic       w_step_level;
   logic       w_halt_level;
   // Debounced levels are not needed by the sequencer; kept on named nets so
   // they are easy to probe.
   logic [2:0] w_unused_levels;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_run),
      .level   (w_run_level),
      .press   (w_run_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_step),
      .level   (w_step_level),
      .press   (w_step_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_halt (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_halt),
      .level   (w_halt_level),
      .press   (w_halt_press)
   );

   assign w_unused_levels = {w_run_level, w_step_level, w_halt_level};

   // ---------------------------------------------------------------- state
   exec_mode_e              r_mode;
   logic [TW-1:0]           r_tick;
   logic                    r_cpu_en;
   logic                    r_halted_bp;
   logic [STEP_CNT_W-1:0]   r_step_count;

   exec_mode_e              w_mode_nxt;
   logic [TW-1:0]           w_tick_nxt;
   logic                    w_halted_bp_nxt;
   logic                    w_cpu_en_nxt;
   logic                    w_bp_hit;

   // The hitting store still completes: cpu_en is already out this cycle,
   // the hit only stops the pulses after it.
   assign w_bp_hit = r_cpu_en & bp_en & mem_write & (mem_adr == bp_addr);

   always_comb begin
      w_mode_nxt      = r_mode;
      w_tick_nxt      = r_tick;
      w_halted_bp_nxt = r_halted_bp;

      case (r_mode)
         MODE_IDLE: begin
            // Halt wins priority but does nothing here, so it swallows any
            // simultaneous step/run press.
            if (!w_halt_press) begin
               if (w_step_press) begin
                  w_mode_nxt = MODE_STEP;
               end else if (w_run_press) begin
                  w_mode_nxt = MODE_RUN;
                  w_tick_nxt = '0;
               end
            end
         end

         MODE_RUN: begin
            // A breakpoint hit and a halt press lead to the same state; the
            // hit is checked first only so that halted_bp gets set.
            if (w_bp_hit) begin
               w_mode_nxt      = MODE_PAUSED;
               w_tick_nxt      = '0;
               w_halted_bp_nxt = 1'b1;
            end else if (w_halt_press) begin
               w_mode_nxt = MODE_PAUSED;
               w_tick_nxt = '0;
            end else if (r_tick == TICK_LAST) begin
               w_tick_nxt = '0;
            end else begin
               w_tick_nxt = r_tick + TW'(1);
            end
         end

         MODE_PAUSED: begin
            w_tick_nxt = '0;
            if (!w_halt_press) begin
               if (w_step_press) begin
                  w_mode_nxt      = MODE_STEP;
                  w_halted_bp_nxt = 1'b0;
               end else if (w_run_press) begin
                  w_mode_nxt      = MODE_RUN;
                  w_halted_bp_nxt = 1'b0;
               end
            end
         end

         MODE_STEP: begin
            // Exactly one pulse; presses arriving now are dropped.
            w_mode_nxt = MODE_PAUSED;
            w_tick_nxt = '0;
            if (w_bp_hit) begin
               w_halted_bp_nxt = 1'b1;
            end
         end

         default: begin
            w_mode_nxt = MODE_IDLE;
            w_tick_nxt = '0;
         end
      endcase

      // cpu_en is registered: decide it from the state and tick being entered
      // so it lines up with mode=STEP or tick==TICK_DIV-1 in the same cycle.
      w_cpu_en_nxt = (w_mode_nxt == MODE_STEP) ||
                     ((w_mode_nxt == MODE_RUN) && (w_tick_nxt == TICK_LAST));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode       <= MODE_IDLE;
         r_tick       <= '0;
         r_cpu_en     <= 1'b0;
         r_halted_bp  <= 1'b0;
         r_step_count <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_tick      <= w_tick_nxt;
         r_cpu_en    <= w_cpu_en_nxt;
         r_halted_bp <= w_halted_bp_nxt;
         if (r_cpu_en) begin
            r_step_count <= r_step_count + STEP_CNT_W'(1);
         end
      end
   end

   assign cpu_en     = r_cpu_en;
   assign mode       = r_mode;
   assign halted_bp  = r_halted_bp;
   assign step_count = r_step_count;

endmodule : exec_controller
